// File: rtl/oversampled_tx_encoder.sv
// Transmit encoder for a 4x-oversampled serial link.
// Bytes arrive over valid/ready, are framed into 4-clock slots and emitted
// as 8-sample OSERDES words (2 bits per word, each bit held for 4 samples).
// Training or idle bytes fill slots with no pending data, and a per-byte
// sub-bit phase offset can delay the whole stream by 0..3 samples.
module oversampled_tx_encoder #(
    parameter logic [7:0] IDLE_BYTE  = 8'h00,
    parameter logic [7:0] TRAIN_BYTE = 8'h55
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       train,
    input  logic [1:0] phase,
    output logic [7:0] sample_window,
    output logic       byte_start,
    output logic       sending_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAIN = 2'd1,
        DATA  = 2'd2
    } state_t;

    logic [1:0] rst_sync;
    logic       rst_int_n;

    state_t     state_q, state_d;
    logic [1:0] cnt_q;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic [1:0] phase_q, phase_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;
    logic       in_ready_q;
    logic [7:0] prev_raw_q;

    logic       bit_lo, bit_hi;
    logic [7:0] raw;
    logic [7:0] window_d;

    assign rst_int_n = rst_sync[1];
    assign in_ready  = in_ready_q;

    // Reset synchronizer: assertion reaches the core immediately, release is clocked in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    // Control state: slot FSM, current byte, latched phase and the 1-deep holding register
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q      <= IDLE;
            tx_byte_q    <= IDLE_BYTE;
            phase_q      <= 2'd0;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            tx_byte_q    <= tx_byte_d;
            phase_q      <= phase_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            in_ready_q   <= !hold_valid_d;
        end
    end

    // Next-slot decision at cnt==3; handshakes and drains never coincide since in_ready is low while full
    always_comb begin
        state_d      = state_q;
        tx_byte_d    = tx_byte_q;
        phase_d      = phase_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (in_valid && in_ready_q) begin
            hold_d       = in_data;
            hold_valid_d = 1'b1;
        end
        if (cnt_q == 2'd3) begin
            phase_d = phase;
            if (train) begin
                state_d   = TRAIN;
                tx_byte_d = TRAIN_BYTE;
            end else if (hold_valid_q) begin
                state_d      = DATA;
                tx_byte_d    = hold_q;
                hold_valid_d = 1'b0;
            end else begin
                state_d   = IDLE;
                tx_byte_d = IDLE_BYTE;
            end
        end
    end

    // Replicate the two bits of this slot position and apply the sample delay using the previous word
    always_comb begin
        bit_lo = tx_byte_q[{cnt_q, 1'b0}];
        bit_hi = tx_byte_q[{cnt_q, 1'b1}];
        raw    = {{4{bit_hi}}, {4{bit_lo}}};
        case (phase_q)
            2'd0:    window_d = raw;
            2'd1:    window_d = {raw[6:0], prev_raw_q[7]};
            2'd2:    window_d = {raw[5:0], prev_raw_q[7:6]};
            default: window_d = {raw[4:0], prev_raw_q[7:5]};
        endcase
    end

    // Free-running slot counter and registered output word with its framing flags
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cnt_q         <= 2'd0;
            prev_raw_q    <= 8'h00;
            sample_window <= 8'h00;
            byte_start    <= 1'b0;
            sending_data  <= 1'b0;
        end else begin
            cnt_q         <= cnt_q + 2'd1;
            prev_raw_q    <= raw;
            sample_window <= window_d;
            byte_start    <= (cnt_q == 2'd0);
            sending_data  <= (state_q == DATA);
        end
    end

endmodule

// File: tb/tb_oversampled_tx_encoder.sv
// Self-checking bench for oversampled_tx_encoder.
// A slot-level model builds the expected sample stream as a bit queue and a
// compare process checks every output on every falling edge; directed
// sequences pin the model with hand-computed words.
module tb_oversampled_tx_encoder;

    localparam logic [7:0] TB_IDLE  = 8'h00;
    localparam logic [7:0] TB_TRAIN = 8'h55;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       train;
    logic [1:0] phase;
    logic [7:0] sample_window;
    logic       byte_start;
    logic       sending_data;

    int checks;
    int errors;

    // model state
    int         m_cnt;
    int         m_sync;
    int         m_phase;
    logic [7:0] m_byte;
    logic [7:0] m_hold;
    logic       m_pend;
    logic       m_data_slot;
    logic       stream[$];
    logic [7:0] exp_window;
    logic       exp_bs;
    logic       exp_sd;
    logic       exp_ready;

    // observation log for the back-to-back test
    logic [7:0] sent_q[$];
    int         run_len;
    int         max_run;

    oversampled_tx_encoder #(
        .IDLE_BYTE (TB_IDLE),
        .TRAIN_BYTE(TB_TRAIN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .train        (train),
        .phase        (phase),
        .sample_window(sample_window),
        .byte_start   (byte_start),
        .sending_data (sending_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic t, input logic [1:0] p);
        in_valid = v;
        in_data  = d;
        train    = t;
        phase    = p;
    endtask

    task automatic modelReset();
        m_cnt       = 0;
        m_sync      = 0;
        m_phase     = 0;
        m_byte      = TB_IDLE;
        m_hold      = 8'h00;
        m_pend      = 1'b0;
        m_data_slot = 1'b0;
        stream.delete();
        for (int k = 0; k < 8; k++) stream.push_back(1'b0);
        exp_window  = 8'h00;
        exp_bs      = 1'b0;
        exp_sd      = 1'b0;
        exp_ready   = 1'b1;
    endtask

    // Slot-level model: each clock appends one word of samples to the stream; the
    // visible window is the latest 8 samples delayed by the byte's phase
    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                modelReset();
            end else if (m_sync < 2) begin
                m_sync++;
            end else begin
                logic lo, hi, hs;
                int   len;
                lo = m_byte[2*m_cnt];
                hi = m_byte[2*m_cnt+1];
                for (int k = 0; k < 8; k++) stream.push_back(k < 4 ? lo : hi);
                len = stream.size();
                for (int j = 0; j < 8; j++) exp_window[j] = stream[len - 8 - m_phase + j];
                exp_bs = (m_cnt == 0);
                exp_sd = m_data_slot;
                hs = in_valid && !m_pend;
                if (m_cnt == 3) begin
                    m_phase = int'(phase);
                    if (train) begin
                        m_byte      = TB_TRAIN;
                        m_data_slot = 1'b0;
                    end else if (m_pend) begin
                        m_byte      = m_hold;
                        m_data_slot = 1'b1;
                        m_pend      = 1'b0;
                    end else begin
                        m_byte      = TB_IDLE;
                        m_data_slot = 1'b0;
                    end
                end
                if (hs) begin
                    m_hold = in_data;
                    m_pend = 1'b1;
                end
                m_cnt     = (m_cnt + 1) % 4;
                exp_ready = !m_pend;
                while (stream.size() > 32) void'(stream.pop_front());
            end
        end
    end

    // Compare every output against the model on each falling edge
    initial begin
        run_len = 0;
        max_run = 0;
        forever begin
            @(negedge clk);
            checkOutput("sample_window", sample_window, exp_window);
            checkOutput("byte_start", {7'b0, byte_start}, {7'b0, exp_bs});
            checkOutput("sending_data", {7'b0, sending_data}, {7'b0, exp_sd});
            checkOutput("in_ready", {7'b0, in_ready}, {7'b0, exp_ready});
            if (sending_data === 1'b1) begin
                sent_q.push_back(sample_window);
                run_len++;
            end else begin
                if (run_len > max_run) max_run = run_len;
                run_len = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to a cycle just after a slot decision edge
    task automatic waitBoundary();
        for (int k = 0; k < 8 && m_cnt != 0; k++) begin
            @(posedge clk);
            #2;
        end
        if (m_cnt != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL boundary_wait: got cnt %0d, expected 0", m_cnt);
        end
    endtask

    // Check the 4 words of the slot decided at the most recent boundary
    task automatic expectWords(input string name, input logic [7:0] w0, input logic [7:0] w1,
                               input logic [7:0] w2, input logic [7:0] w3, input logic sd);
        logic [7:0] w[4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s_word%0d", name, i), sample_window, w[i]);
            checkOutput($sformatf("%s_sd%0d", name, i), {7'b0, sending_data}, {7'b0, sd});
            checkOutput($sformatf("%s_bs%0d", name, i), {7'b0, byte_start}, (i == 0) ? 8'd1 : 8'd0);
        end
    endtask

    initial begin
        logic [7:0] b2b[3];
        logic [7:0] b2b_words[12];
        int         pulses;
        logic       got_hs;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_window", sample_window, 8'h00);
        checkOutput("reset_in_ready", {7'b0, in_ready}, 8'd1);
        checkOutput("reset_bs", {7'b0, byte_start}, 8'd0);
        checkOutput("reset_sd", {7'b0, sending_data}, 8'd0);
        #1 rst_n = 1'b1;

        // idle after reset: byte_start every 4th word, zero window
        repeat (2) @(posedge clk);
        #2;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (byte_start === 1'b1) pulses++;
            checkOutput("idle_window", sample_window, 8'h00);
        end
        checkOutput("idle_bs_pulses", pulses[7:0], 8'd3);
        checkOutput("idle_in_ready", {7'b0, in_ready}, 8'd1);

        // single data byte A5
        waitBoundary();
        applyStimulus(1'b1, 8'hA5, 1'b0, 2'd0);
        @(posedge clk);
        #2;
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0);
        checkOutput("a5_ready_low", {7'b0, in_ready}, 8'd0);
        waitBoundary();
        checkOutput("a5_ready_after_load", {7'b0, in_ready}, 8'd1);
        expectWords("a5", 8'h0F, 8'h0F, 8'hF0, 8'hF0, 1'b1);

        // training holds off a pending byte until train drops
        applyStimulus(1'b1, 8'h3C, 1'b1, 2'd0);
        @(posedge clk);
        #2;
        applyStimulus(1'b0, 8'h00, 1'b1, 2'd0);
        checkOutput("train_ready_low", {7'b0, in_ready}, 8'd0);
        waitBoundary();
        expectWords("train1", 8'h0F, 8'h0F, 8'h0F, 8'h0F, 1'b0);
        expectWords("train2", 8'h0F, 8'h0F, 8'h0F, 8'h0F, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0);
        expectWords("train3", 8'h0F, 8'h0F, 8'h0F, 8'h0F, 1'b0);
        expectWords("held3c", 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b1);

        // phase 1: FF after idle, then idle after FF
        applyStimulus(1'b1, 8'hFF, 1'b0, 2'd1);
        @(posedge clk);
        #2;
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd1);
        waitBoundary();
        expectWords("ph1_ff", 8'hFE, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        expectWords("ph1_idle", 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);

        // other phases and phase steps, checked by the model
        applyStimulus(1'b1, 8'h96, 1'b0, 2'd2);
        @(posedge clk);
        #2;
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd2);
        waitBoundary();
        applyStimulus(1'b1, 8'h5A, 1'b0, 2'd3);
        @(posedge clk);
        #2;
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd3);
        waitBoundary();
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0);
        repeat (8) @(posedge clk);
        #2;
        waitBoundary();

        // back-to-back bytes in consecutive slots
        b2b[0] = 8'h01; b2b[1] = 8'h02; b2b[2] = 8'h03;
        b2b_words = '{8'h0F, 8'h00, 8'h00, 8'h00,
                      8'hF0, 8'h00, 8'h00, 8'h00,
                      8'hFF, 8'h00, 8'h00, 8'h00};
        sent_q.delete();
        max_run = 0;
        for (int b = 0; b < 3; b++) begin
            applyStimulus(1'b1, b2b[b], 1'b0, 2'd0);
            got_hs = 1'b0;
            for (int k = 0; k < 16 && !got_hs; k++) begin
                logic rdy;
                rdy = (in_ready === 1'b1);
                @(posedge clk);
                #2;
                got_hs = rdy;
            end
            checkOutput($sformatf("b2b_handshake%0d", b), {7'b0, got_hs}, 8'd1);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0);
        repeat (16) @(posedge clk);
        #2;
        checkOutput("b2b_word_count", sent_q.size() > 255 ? 8'hFF : 8'(sent_q.size()), 8'd12);
        for (int i = 0; i < 12 && i < sent_q.size(); i++)
            checkOutput($sformatf("b2b_word%0d", i), sent_q[i], b2b_words[i]);
        checkOutput("b2b_contiguous", max_run > 255 ? 8'hFF : 8'(max_run), 8'd12);

        // reset in the middle of a DATA slot with the holding register full
        waitBoundary();
        applyStimulus(1'b1, 8'h81, 1'b0, 2'd0);
        @(posedge clk);
        #2;
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0);
        waitBoundary();
        applyStimulus(1'b1, 8'h7E, 1'b0, 2'd0);
        @(posedge clk);
        #2;
        applyStimulus(1'b0, 8'h00, 1'b0, 2'd0);
        @(posedge clk);
        #2;
        checkOutput("mid_hold_full", {7'b0, in_ready}, 8'd0);
        checkOutput("mid_sending", {7'b0, sending_data}, 8'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_window", sample_window, 8'h00);
        checkOutput("mid_rst_sd", {7'b0, sending_data}, 8'd0);
        checkOutput("mid_rst_bs", {7'b0, byte_start}, 8'd0);
        checkOutput("mid_rst_ready", {7'b0, in_ready}, 8'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        expectWords("post_rst1", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        expectWords("post_rst2", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/oversampled_tx_encoder.md
Name: oversampled_tx_encoder

Overview:
- Transmit-side counterpart of the 4x-oversampling data recovery path.
- Accepts bytes over a valid/ready handshake and emits one 8-sample word per clock to the OSERDES. Each word carries 2 data bits, and each bit is replicated over 4 samples.
- Sends a training byte or an idle byte when no data is pending.
- A programmable sub-bit phase offset (0-3 samples) lets loopback benches exercise receiver phase tracking.

Parameters:
- IDLE_BYTE, 8'h00, byte sent in slots where no data is pending and training is off.
- TRAIN_BYTE, 8'h55, byte sent repeatedly while train is high (alternating bits give an edge every bit).

Ports:
- clk  in  1  single clock; also the OSERDES parallel clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  byte to transmit; sent LSB first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  holding register is empty; a handshake occurs when in_valid && in_ready.
- train  in  1  request training pattern; takes priority over data.
- phase  in  2  sample delay applied to the output stream, 0..3 samples.
- sample_window  out  8  OSERDES word; bit 0 is the earliest sample in time, bit 7 the latest.
- byte_start  out  1  one-cycle pulse aligned with the first word of every transmitted byte.
- sending_data  out  1  high for all 4 words of a byte taken from in_data.

Behaviour:
- Reset (async assert, sync release internally):
  - sample_window = 8'h00, byte_start = 0, sending_data = 0, in_ready = 1.
  - Holding register empty, slot counter = 0, state = IDLE, phase_q = 0, prev_raw = 8'h00.
- Slot counter cnt (2 bit) runs continuously 0,1,2,3,0...; one byte slot is 4 clocks.
- Holding register (1 deep):
  - Handshake loads in_data and sets hold_valid; in_ready = !hold_valid.
  - in_ready is registered, with no combinational path from in_valid.
  - A handshake in the same cycle as a drain of the holding register is not allowed, because in_ready is low then.
- FSM states IDLE, TRAIN, DATA; the decision is taken at the edge where cnt==3 (the next-slot boundary):
  - if train == 1: state = TRAIN, tx_byte = TRAIN_BYTE.
  - else if hold_valid: state = DATA, tx_byte = hold, clear hold_valid (in_ready rises next cycle).
  - else: state = IDLE, tx_byte = IDLE_BYTE.
  - phase_q <= phase at the same edge, so phase changes only at byte boundaries.
- The first slot after reset is IDLE with tx_byte = IDLE_BYTE; the first decision is at the first cnt==3 edge.
- A train assertion mid-slot does not truncate the byte in flight; it takes effect at the next boundary. A pending data byte stays held until train drops.
- Word formation:
  - raw = {4{tx_byte[2*cnt+1]}, 4{tx_byte[2*cnt]}}. Bit 2*cnt occupies samples [3:0], bit 2*cnt+1 occupies samples [7:4].
  - prev_raw <= raw every cycle.
  - sample_window <= ({raw, prev_raw} >> (8 - phase_q))[7:0]. With phase_q = 0 this is raw; with phase_q = k, the k earliest samples come from the previous word's top samples.
- Latency: a byte loaded into tx_byte at edge T has its bits 0/1 on sample_window after edge T+1, and its bits 6/7 after edge T+4.
- byte_start and sending_data are registered alongside sample_window, so they stay aligned with the word that carries bits 0/1.
- A phase change of +1 between bytes repeats one sample; a change of -1 drops one sample. Both are intended and not corrected.
- Reset mid-byte aborts the slot immediately: a pending held byte is lost, and the output returns to 8'h00 asynchronously.

Test Plan:
- Reset, no input, train=0, phase=0 -> sample_window constant 8'h00, in_ready=1, byte_start pulses every 4th cycle, sending_data=0.
- in_data=8'hA5 handshaken during slot 0 -> in next slot sample_window = 8'h0F, 8'h0F, 8'hF0, 8'hF0; sending_data=1 for exactly those 4 cycles; in_ready low from the handshake until the cycle after the load.
- train=1 held, phase=0 -> sample_window alternates 8'h0F every cycle (8'h55 pattern); a held data byte is not sent until train drops, then appears at the next boundary.
- phase=1 with data 8'hFF following IDLE_BYTE -> first data word 8'hFE, then 8'hFF; the first IDLE word after the data is 8'h01.
- Back-to-back in_valid with bytes 8'h01, 8'h02, 8'h03 -> bytes sent in consecutive slots with no IDLE slot between them; each in_ready rise is one cycle after its load.
- rst_n asserted at cnt==2 of a DATA slot with the holding register full -> outputs zero immediately; after release, the first slot is IDLE and the held byte is not transmitted.
